bridge_rx_wide: RTL and testbench
=================================

BRIDGE_RX_WIDE -- requirements
Module: bridge_rx_wide

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: address width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 Parameter DATA_WIDTH, default 16: data width in bits; SHALL be a multiple of 4 and at least 4.
REQ-003 Parameter TIMEOUT_CYCLES, default 0: maximum idle cycles between bytes within a frame; 0 disables the timeout.
REQ-004 The ports SHALL be, in this order:
- clk  input  1: single clock; all logic on rising edge.
- rst_n  input  1: reset, asynchronous, active-low.
- data_i  input  8: received UART byte.
- valid_i  input  1: data_i valid this cycle; one byte per asserted cycle.
- addr_o  output  ADDR_WIDTH: request address.
- data_o  output  DATA_WIDTH: write data; 0 for reads.
- rw_o  output  1: 1 = write, 0 = read.
- valid_o  output  1: request pending.
- ready_i  input  1: consumer accepts the request.
- err_o  output  1: one-cycle error pulse.
- err_code_o  output  2: error cause (1 bad char, 2 timeout, 3 overrun); held until the next err_o.

Function
REQ-005 Let NA = ADDR_WIDTH/4 and ND = DATA_WIDTH/4.
REQ-006 Frame formats:
- Read frame: 'R' or 'r', then NA hex digits, then CR (0x0D) or LF (0x0A).
- Write frame: 'W' or 'w', then NA address digits, then ND data digits, then CR or LF.
- Hex digits accepted: 0-9, A-F, a-f.
REQ-007 The parser SHALL use the states IDLE, ADDR, DATA and EOL, with a digit counter sized for max(NA, ND).
REQ-008 IDLE transitions:
- 'R'/'r' -> ADDR with the read flag set.
- 'W'/'w' -> ADDR with the write flag set.
- Any other byte is ignored; no error is raised.
REQ-009 ADDR: each hex digit SHALL shift into the address accumulator, MSB first. After digit NA the state SHALL go to DATA on a write or to EOL on a read.
REQ-010 DATA: each hex digit SHALL shift into the data accumulator, MSB first. After digit ND the state SHALL go to EOL.
REQ-011 In ADDR or DATA, a non-hex byte SHALL:
- return the parser to IDLE and discard the byte (it does not start a new frame);
- pulse err_o with err_code_o = 1.
REQ-012 EOL: CR or LF SHALL complete the frame. Any other byte SHALL return the parser to IDLE and raise error code 1.
REQ-013 On completion, the output register loads addr_o, data_o (0 for reads), rw_o and valid_o = 1 on the clock edge after the terminator byte (1-cycle latency), provided the register is free.
REQ-014 The output register is free when valid_o = 0, or when valid_o = 1 and ready_i = 1 in the same cycle; in the latter case the new request replaces the old one with no gap and no error.
REQ-015 If a frame completes while valid_o = 1 and ready_i = 0:
- the new frame SHALL be dropped;
- the pending request SHALL stay unchanged;
- err_o SHALL pulse with err_code_o = 3.
REQ-016 Once valid_o is asserted, addr_o, data_o and rw_o SHALL stay stable until ready_i is sampled high.
REQ-017 When accepted (valid_o && ready_i) with no new frame completing, valid_o SHALL deassert the next cycle and addr_o, data_o and rw_o SHALL return to 0.
REQ-018 Parsing SHALL continue regardless of valid_o; the input path is never back-pressured.
REQ-019 Timeout (TIMEOUT_CYCLES > 0):
- An idle counter clears on every valid_i cycle and in IDLE.
- If the state is not IDLE and TIMEOUT_CYCLES consecutive cycles pass without valid_i, the parser SHALL return to IDLE and pulse err_o with err_code_o = 2.
REQ-020 If two error conditions occur in the same cycle, the priority SHALL be overrun (3) > bad char (1) > timeout (2).
REQ-021 Accumulators SHALL clear on entry to ADDR, so a partial frame never leaks into a later request.

Reset
REQ-022 While rst_n = 0, asynchronously and independent of clk:
- state = IDLE;
- the counters and accumulators = 0;
- addr_o = 0, data_o = 0, rw_o = 0, valid_o = 0, err_o = 0, err_code_o = 0.
REQ-023 Reset asserted mid-frame or with a pending request SHALL discard both, with no error pulse. The first byte after deassertion SHALL be parsed from IDLE.

Verification
REQ-024 Defaults: "R1234\r" with ready_i = 1 -> one cycle later addr_o = 0x1234, rw_o = 0, data_o = 0, valid_o = 1 for exactly 1 cycle.
REQ-025 ADDR_WIDTH = 32, DATA_WIDTH = 24: "wdeadBEEF00abcd\n" -> addr_o = 0xDEADBEEF, data_o = 0x00ABCD, rw_o = 1.
REQ-026 "R12G4\r" -> err_o pulses with code 1 on the cycle after 'G'; no valid_o; a following "R0001\n" yields addr_o = 0x0001.
REQ-027 ready_i = 0: "W00010002\r" then "R0003\r" -> the first request is held; err_code_o = 3 after the second frame; after ready_i = 1, addr_o = 0x0001 and data_o = 0x0002 are accepted once.
REQ-028 TIMEOUT_CYCLES = 10: "R12" then 10 idle cycles -> err_o with code 2. Then "34\r" produces no request, and "R0034\r" produces addr_o = 0x0034.
REQ-029 rst_n pulsed low between the 'W' and the 4th digit of a write frame -> all outputs 0 immediately, and no request is produced from the remainder of that frame.

Source files
------------

// File: rtl/bridge_rx_wide.sv
// bridge_rx_wide: parses ASCII read/write command frames from a UART byte
// stream ("Raaaa\r", "Waaaadddd\n") into a single-entry request register with
// a valid/ready handshake. It also reports malformed, stalled and overrun frames.
module bridge_rx_wide #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            data_i,
    input  logic                  valid_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  rw_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  err_o,
    output logic [1:0]            err_code_o
);

    localparam int NA    = ADDR_WIDTH / 4;
    localparam int ND    = DATA_WIDTH / 4;
    localparam int MAXD  = (NA > ND) ? NA : ND;
    localparam int CNT_W = (MAXD > 1) ? $clog2(MAXD) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] NA_LAST  = CNT_W'(NA - 1);
    localparam logic [CNT_W-1:0] ND_LAST  = CNT_W'(ND - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_EOL  = 2'd3
    } state_t;

    state_t                  state_r;
    logic                    write_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [TO_W-1:0]         idle_cnt_r;
    logic [ADDR_WIDTH-1:0]   addr_acc_r;
    logic [DATA_WIDTH-1:0]   data_acc_r;

    logic [4:0]              hex_dec_s;
    logic                    is_hex_s;
    logic [3:0]              hex_val_s;
    logic                    is_eol_s;
    logic                    is_r_s;
    logic                    is_w_s;
    logic                    bad_char_s;
    logic                    done_s;
    logic                    timeout_s;
    logic                    free_s;
    logic                    overrun_s;

    // ASCII hex decode: bit 4 flags a legal digit, bits 3:0 carry its value.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, c[3:0]};
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            r = {1'b1, 4'(c[3:0] + 4'd9)};
        end else begin
            r = 5'd0;
        end
        return r;
    endfunction

    // Byte classification and per-cycle event detection (completion, errors).
    always_comb begin
        hex_dec_s  = hex_decode(data_i);
        is_hex_s   = hex_dec_s[4];
        hex_val_s  = hex_dec_s[3:0];
        is_eol_s   = (data_i == 8'h0D) || (data_i == 8'h0A);
        is_r_s     = (data_i == 8'h52) || (data_i == 8'h72);
        is_w_s     = (data_i == 8'h57) || (data_i == 8'h77);
        bad_char_s = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            ST_ADDR, ST_DATA: bad_char_s = valid_i && !is_hex_s;
            ST_EOL: begin
                bad_char_s = valid_i && !is_eol_s;
                done_s     = valid_i && is_eol_s;
            end
            default: begin
                bad_char_s = 1'b0;
                done_s     = 1'b0;
            end
        endcase
        timeout_s = (TIMEOUT_CYCLES > 0) && (state_r != ST_IDLE) && !valid_i &&
                    (idle_cnt_r == TO_LAST);
        // A completing frame may replace a request that is being accepted this cycle.
        free_s    = !valid_o || ready_i;
        overrun_s = done_s && !free_s;
    end

    // Frame parser: state, digit counter, idle counter and accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            write_r    <= 1'b0;
            cnt_r      <= '0;
            idle_cnt_r <= '0;
            addr_acc_r <= '0;
            data_acc_r <= '0;
        end else begin
            if (timeout_s) begin
                state_r <= ST_IDLE;
                cnt_r   <= '0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (valid_i && (is_r_s || is_w_s)) begin
                            state_r    <= ST_ADDR;
                            write_r    <= is_w_s;
                            cnt_r      <= '0;
                            addr_acc_r <= '0;
                            data_acc_r <= '0;
                        end
                    end
                    ST_ADDR: begin
                        if (valid_i && is_hex_s) begin
                            addr_acc_r <= (addr_acc_r << 4) | ADDR_WIDTH'(hex_val_s);
                            if (cnt_r == NA_LAST) begin
                                cnt_r   <= '0;
                                state_r <= write_r ? ST_DATA : ST_EOL;
                            end else begin
                                cnt_r <= cnt_r + CNT_W'(1);
                            end
                        end else if (valid_i) begin
                            state_r <= ST_IDLE;
                            cnt_r   <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (valid_i && is_hex_s) begin
                            data_acc_r <= (data_acc_r << 4) | DATA_WIDTH'(hex_val_s);
                            if (cnt_r == ND_LAST) begin
                                cnt_r   <= '0;
                                state_r <= ST_EOL;
                            end else begin
                                cnt_r <= cnt_r + CNT_W'(1);
                            end
                        end else if (valid_i) begin
                            state_r <= ST_IDLE;
                            cnt_r   <= '0;
                        end
                    end
                    ST_EOL: begin
                        if (valid_i) begin
                            state_r <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                    end
                endcase
            end
            // Gap timer only runs inside a frame and restarts on every byte.
            if (state_r == ST_IDLE || valid_i || timeout_s || TIMEOUT_CYCLES == 0) begin
                idle_cnt_r <= '0;
            end else begin
                idle_cnt_r <= idle_cnt_r + TO_W'(1);
            end
        end
    end

    // Request register: load on completion when free, clear after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_o  <= '0;
            data_o  <= '0;
            rw_o    <= 1'b0;
            valid_o <= 1'b0;
        end else if (done_s && free_s) begin
            addr_o  <= addr_acc_r;
            data_o  <= write_r ? data_acc_r : '0;
            rw_o    <= write_r;
            valid_o <= 1'b1;
        end else if (valid_o && ready_i) begin
            addr_o  <= '0;
            data_o  <= '0;
            rw_o    <= 1'b0;
            valid_o <= 1'b0;
        end
    end

    // Error pulse with prioritised cause; the code persists until the next pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_o      <= 1'b0;
            err_code_o <= 2'd0;
        end else begin
            err_o <= overrun_s || bad_char_s || timeout_s;
            if (overrun_s) begin
                err_code_o <= 2'd3;
            end else if (bad_char_s) begin
                err_code_o <= 2'd1;
            end else if (timeout_s) begin
                err_code_o <= 2'd2;
            end
        end
    end

endmodule

// File: tb/tb_bridge_rx_wide.sv
// Directed bench for bridge_rx_wide: three instances share one byte stream
// (default widths, 32/24-bit widths, and default widths with a 10-cycle timeout).
module tb_bridge_rx_wide;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data_i = 8'h00;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;

    logic [15:0] a0_addr, a0_data;
    logic        a0_rw, a0_valid, a0_err;
    logic [1:0]  a0_code;
    logic [31:0] a1_addr;
    logic [23:0] a1_data;
    logic        a1_rw, a1_valid, a1_err;
    logic [1:0]  a1_code;
    logic [15:0] a2_addr, a2_data;
    logic        a2_rw, a2_valid, a2_err;
    logic [1:0]  a2_code;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bridge_rx_wide u_def (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
        .addr_o(a0_addr), .data_o(a0_data), .rw_o(a0_rw), .valid_o(a0_valid),
        .ready_i(ready_i), .err_o(a0_err), .err_code_o(a0_code)
    );

    bridge_rx_wide #(.ADDR_WIDTH(32), .DATA_WIDTH(24)) u_wide (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
        .addr_o(a1_addr), .data_o(a1_data), .rw_o(a1_rw), .valid_o(a1_valid),
        .ready_i(ready_i), .err_o(a1_err), .err_code_o(a1_code)
    );

    bridge_rx_wide #(.TIMEOUT_CYCLES(10)) u_to (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
        .addr_o(a2_addr), .data_o(a2_data), .rw_o(a2_rw), .valid_o(a2_valid),
        .ready_i(ready_i), .err_o(a2_err), .err_code_o(a2_code)
    );

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        data_i  = b;
        valid_i = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
        end
    endtask

    // One cycle with no byte; afterwards outputs reflect the previous byte.
    task automatic idle();
        @(negedge clk);
        data_i  = 8'h00;
        valid_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({a0_addr, a0_data, a0_rw, a0_valid, a0_err, a0_code} !== 37'd0) begin errors++; $display("FAIL reset_def got=%h exp=0", {a0_addr, a0_data, a0_rw, a0_valid, a0_err, a0_code}); end
        checks++; if ({a1_addr, a1_data, a1_rw, a1_valid, a1_err, a1_code} !== 61'd0) begin errors++; $display("FAIL reset_wide got=%h exp=0", {a1_addr, a1_data, a1_rw, a1_valid, a1_err, a1_code}); end
        checks++; if ({a2_addr, a2_data, a2_rw, a2_valid, a2_err, a2_code} !== 37'd0) begin errors++; $display("FAIL reset_to got=%h exp=0", {a2_addr, a2_data, a2_rw, a2_valid, a2_err, a2_code}); end
    endtask

    task automatic test_read();
        do_reset();
        ready_i = 1'b1;
        send_str("R1234\r");
        idle();
        checks++; if ({a0_valid, a0_rw, a0_addr, a0_data} !== {1'b1, 1'b0, 16'h1234, 16'h0000}) begin errors++; $display("FAIL read_req got v=%b rw=%b a=%h d=%h exp v=1 rw=0 a=1234 d=0000", a0_valid, a0_rw, a0_addr, a0_data); end
        idle();
        checks++; if ({a0_valid, a0_addr} !== {1'b0, 16'h0000}) begin errors++; $display("FAIL read_clear got v=%b a=%h exp v=0 a=0000", a0_valid, a0_addr); end
    endtask

    task automatic test_wide_write();
        do_reset();
        ready_i = 1'b1;
        send_str("wdeadBEEF00abcd\n");
        idle();
        checks++; if ({a1_valid, a1_rw, a1_addr, a1_data, a1_err} !== {1'b1, 1'b1, 32'hDEADBEEF, 24'h00ABCD, 1'b0}) begin errors++; $display("FAIL wide_write got v=%b rw=%b a=%h d=%h e=%b exp v=1 rw=1 a=deadbeef d=00abcd e=0", a1_valid, a1_rw, a1_addr, a1_data, a1_err); end
    endtask

    task automatic test_bad_char();
        do_reset();
        ready_i = 1'b1;
        send_str("R12G");
        idle();
        checks++; if ({a0_err, a0_code, a0_valid} !== {1'b1, 2'd1, 1'b0}) begin errors++; $display("FAIL badchar_pulse got e=%b c=%0d v=%b exp e=1 c=1 v=0", a0_err, a0_code, a0_valid); end
        idle();
        checks++; if ({a0_err, a0_code} !== {1'b0, 2'd1}) begin errors++; $display("FAIL badchar_hold got e=%b c=%0d exp e=0 c=1", a0_err, a0_code); end
        send_str("4\r");
        idle();
        checks++; if ({a0_valid, a0_err} !== 2'b00) begin errors++; $display("FAIL badchar_tail got v=%b e=%b exp v=0 e=0", a0_valid, a0_err); end
        send_str("R0001\n");
        idle();
        checks++; if ({a0_valid, a0_addr} !== {1'b1, 16'h0001}) begin errors++; $display("FAIL badchar_recover got v=%b a=%h exp v=1 a=0001", a0_valid, a0_addr); end
        send_str("R1234X");
        idle();
        checks++; if ({a0_err, a0_code, a0_valid} !== {1'b1, 2'd1, 1'b0}) begin errors++; $display("FAIL eol_bad got e=%b c=%0d v=%b exp e=1 c=1 v=0", a0_err, a0_code, a0_valid); end
    endtask

    task automatic test_overrun();
        do_reset();
        send_str("W00010002\r");
        idle();
        checks++; if ({a0_valid, a0_rw, a0_addr, a0_data} !== {1'b1, 1'b1, 16'h0001, 16'h0002}) begin errors++; $display("FAIL ovr_first got v=%b rw=%b a=%h d=%h exp v=1 rw=1 a=0001 d=0002", a0_valid, a0_rw, a0_addr, a0_data); end
        send_str("R0003\r");
        idle();
        checks++; if ({a0_err, a0_code, a0_valid, a0_rw, a0_addr, a0_data} !== {1'b1, 2'd3, 1'b1, 1'b1, 16'h0001, 16'h0002}) begin errors++; $display("FAIL ovr_drop got e=%b c=%0d v=%b rw=%b a=%h d=%h exp e=1 c=3 v=1 rw=1 a=0001 d=0002", a0_err, a0_code, a0_valid, a0_rw, a0_addr, a0_data); end
        @(negedge clk);
        ready_i = 1'b1;
        @(negedge clk);
        checks++; if ({a0_valid, a0_err, a0_code, a0_addr} !== {1'b0, 1'b0, 2'd3, 16'h0000}) begin errors++; $display("FAIL ovr_accept got v=%b e=%b c=%0d a=%h exp v=0 e=0 c=3 a=0000", a0_valid, a0_err, a0_code, a0_addr); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_str("R00AA\r");
        idle();
        checks++; if ({a0_valid, a0_addr} !== {1'b1, 16'h00AA}) begin errors++; $display("FAIL b2b_first got v=%b a=%h exp v=1 a=00aa", a0_valid, a0_addr); end
        send_str("R00BB");
        @(negedge clk);
        data_i  = 8'h0D;
        valid_i = 1'b1;
        ready_i = 1'b1;
        idle();
        checks++; if ({a0_valid, a0_addr, a0_err} !== {1'b1, 16'h00BB, 1'b0}) begin errors++; $display("FAIL b2b_replace got v=%b a=%h e=%b exp v=1 a=00bb e=0", a0_valid, a0_addr, a0_err); end
        idle();
        checks++; if (a0_valid !== 1'b0) begin errors++; $display("FAIL b2b_done got v=%b exp v=0", a0_valid); end
    endtask

    task automatic test_timeout();
        do_reset();
        ready_i = 1'b1;
        send_str("R12");
        repeat (10) idle();
        checks++; if (a2_err !== 1'b0) begin errors++; $display("FAIL to_early got e=%b exp e=0", a2_err); end
        idle();
        checks++; if ({a2_err, a2_code} !== {1'b1, 2'd2}) begin errors++; $display("FAIL to_pulse got e=%b c=%0d exp e=1 c=2", a2_err, a2_code); end
        send_str("34\r");
        idle();
        checks++; if (a2_valid !== 1'b0) begin errors++; $display("FAIL to_tail got v=%b exp v=0", a2_valid); end
        checks++; if ({a0_valid, a0_addr} !== {1'b1, 16'h1234}) begin errors++; $display("FAIL to_disabled got v=%b a=%h exp v=1 a=1234", a0_valid, a0_addr); end
        send_str("R0034\r");
        idle();
        checks++; if ({a2_valid, a2_addr, a2_data, a2_rw} !== {1'b1, 16'h0034, 16'h0000, 1'b0}) begin errors++; $display("FAIL to_recover got v=%b a=%h d=%h rw=%b exp v=1 a=0034 d=0000 rw=0", a2_valid, a2_addr, a2_data, a2_rw); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        send_str("RX");
        idle();
        send_str("R5555\r");
        send_str("W00");
        idle();
        checks++; if ({a0_valid, a0_addr, a0_code} !== {1'b1, 16'h5555, 2'd1}) begin errors++; $display("FAIL mid_pending got v=%b a=%h c=%0d exp v=1 a=5555 c=1", a0_valid, a0_addr, a0_code); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({a0_addr, a0_data, a0_rw, a0_valid, a0_err, a0_code} !== 37'd0) begin errors++; $display("FAIL mid_async got=%h exp=0", {a0_addr, a0_data, a0_rw, a0_valid, a0_err, a0_code}); end
        @(negedge clk);
        rst_n   = 1'b1;
        ready_i = 1'b1;
        send_str("10002\r");
        idle();
        checks++; if ({a0_valid, a0_err} !== 2'b00) begin errors++; $display("FAIL mid_remainder got v=%b e=%b exp v=0 e=0", a0_valid, a0_err); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_wide_write();
        test_bad_char();
        test_overrun();
        test_back_to_back();
        test_timeout();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
